// File: rtl/pla_search_pkg.sv
// pla_search_pkg: shared state encoding, default widths and masked-compare helper
package pla_search_pkg;

   localparam int NI_DEF = 8;
   localparam int NO_DEF = 16;

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

   // Callers zero-extend to 64 bits so one helper serves any NO up to 64
   function automatic logic masked_match(input logic [63:0] z, input logic [63:0] t, input logic [63:0] m);
      return ((z ^ t) & m) == 64'd0;
   endfunction

endpackage

// File: rtl/pla_inverse_search.sv
// pla_inverse_search: sweeps PLA input codes to find the first, or count all,
// codes whose output matches a masked target pattern.
module pla_inverse_search
   import pla_search_pkg::*;
#(
   parameter int NI = NI_DEF,
   parameter int NO = NO_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [NO-1:0] req_target,
   input  logic [NO-1:0] req_mask,
   input  logic          req_first_only,
   output logic [NI-1:0] eval_x,
   input  logic [NO-1:0] eval_z,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic          resp_found,
   output logic [NI-1:0] resp_x,
   output logic [NI:0]   resp_count
);

   state_e        state_q, state_d;
   logic [NI-1:0] cnt_q, cnt_d, x_q, x_d;
   logic [NI:0]   count_q, count_d;
   logic          found_q, found_d, first_q, first_d;
   logic [NO-1:0] target_q, target_d, mask_q, mask_d;
   logic          hit;

   assign hit        = (state_q == SCAN) && masked_match(64'(eval_z), 64'(target_q), 64'(mask_q));
   assign req_ready  = state_q == IDLE;
   assign resp_valid = state_q == RESP;
   assign eval_x     = (state_q == SCAN) ? cnt_q : '0;
   assign resp_found = found_q;
   assign resp_x     = x_q;
   assign resp_count = count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         count_q  <= '0;
         found_q  <= 1'b0;
         x_q      <= '0;
         first_q  <= 1'b0;
         target_q <= '0;
         mask_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         count_q  <= count_d;
         found_q  <= found_d;
         x_q      <= x_d;
         first_q  <= first_d;
         target_q <= target_d;
         mask_q   <= mask_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      count_d  = count_q;
      found_d  = found_q;
      x_d      = x_q;
      first_d  = first_q;
      target_d = target_q;
      mask_d   = mask_q;
      case (state_q)
         IDLE: if (req_valid) begin
            state_d  = SCAN;
            target_d = req_target;
            mask_d   = req_mask;
            first_d  = req_first_only;
            cnt_d    = '0;
            count_d  = '0;
            found_d  = 1'b0;
            x_d      = '0;
         end
         SCAN: begin
            if (hit) begin
               count_d = count_q + 1'b1;
               if (!found_q) begin
                  found_d = 1'b1;
                  x_d     = cnt_q;
               end
            end
            // The last code is evaluated without advancing cnt, so it never wraps
            if ((first_q && hit) || (&cnt_q)) state_d = RESP;
            else cnt_d = cnt_q + 1'b1;
         end
         RESP: if (resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pla_inverse_search.sv
// tb_pla_inverse_search: directed requests with a scoreboard queue of expected
// responses, popped by a monitor when resp_valid rises.
module tb_pla_inverse_search;
   import pla_search_pkg::*;

   typedef struct {
      logic       found;
      logic [7:0] x;
      logic [8:0] count;
      int         lat;
      int         acc;
   } exp_t;

   logic        clk = 0, rst = 1;
   logic        req_valid = 0, req_ready, req_first_only = 0;
   logic [15:0] req_target = 0, req_mask = 0, eval_z;
   logic [7:0]  eval_x, resp_x;
   logic        resp_valid, resp_ready = 1, resp_found;
   logic [8:0]  resp_count;
   logic        inv = 0, prev_valid = 0;
   int          cyc = 0, checks = 0, errors = 0;
   exp_t        q[$];

   pla_inverse_search #(.NI(8), .NO(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_target(req_target), .req_mask(req_mask), .req_first_only(req_first_only),
      .eval_x(eval_x), .eval_z(eval_z), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_found(resp_found), .resp_x(resp_x), .resp_count(resp_count)
   );

   assign eval_z = inv ? {eval_x, ~eval_x} : {eval_x, eval_x};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) prev_valid <= 1'b0;
      else begin
         prev_valid <= resp_valid;
         if (resp_valid && !prev_valid) begin
            if (q.size() == 0) chk("unexpected_resp", 1, 0);
            else begin
               exp_t e;
               e = q.pop_front();
               chk("resp_found", 32'(resp_found), 32'(e.found));
               chk("resp_x", 32'(resp_x), 32'(e.x));
               chk("resp_count", 32'(resp_count), 32'(e.count));
               chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
         end
      end
   end

   task automatic issue(input logic [15:0] t, input logic [15:0] m, input logic f, input logic ef,
                        input logic [7:0] ex, input logic [8:0] ec, input int lat, input logic track);
      exp_t e;
      int n = 0;
      while (!req_ready && n < 1000) begin @(negedge clk); n++; end
      if (n >= 1000) chk("ready_timeout", 0, 1);
      req_valid = 1; req_target = t; req_mask = m; req_first_only = f;
      @(posedge clk); #1;
      req_valid = 0;
      e.found = ef; e.x = ex; e.count = ec; e.lat = lat; e.acc = cyc;
      if (track) q.push_back(e);
   endtask

   task automatic wait_resp();
      int n = 0;
      do begin @(negedge clk); n++; end while (!resp_valid && n < 600);
      if (!resp_valid) chk("resp_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 1);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_found", 32'(resp_found), 0);
      chk("rst_x", 32'(resp_x), 0);
      chk("rst_count", 32'(resp_count), 0);
      chk("rst_eval_x", 32'(eval_x), 0);

      issue(16'h5A5A, 16'hFFFF, 1, 1, 8'h5A, 9'd1, 91, 1);   wait_resp();
      issue(16'h0003, 16'h000F, 0, 1, 8'h03, 9'd16, 256, 1); wait_resp();
      inv = 1;
      issue(16'h0000, 16'hFFFF, 0, 0, 8'h00, 9'd0, 256, 1);  wait_resp();
      inv = 0;
      issue(16'h1234, 16'h0000, 0, 1, 8'h00, 9'h100, 256, 1); wait_resp();
      issue(16'h1234, 16'h0000, 1, 1, 8'h00, 9'd1, 1, 1);     wait_resp();

      resp_ready = 0;
      issue(16'h0707, 16'hFFFF, 1, 1, 8'h07, 9'd1, 8, 1);
      begin
         int n = 0;
         while (!resp_valid && n < 100) begin @(negedge clk); n++; end
      end
      for (int i = 0; i < 10; i++) begin
         req_valid = i[0]; req_target = 16'h0101 * 16'(i);
         @(negedge clk);
         chk("bp_valid", 32'(resp_valid), 1);
         chk("bp_ready", 32'(req_ready), 0);
         chk("bp_found", 32'(resp_found), 1);
         chk("bp_x", 32'(resp_x), 8'h07);
         chk("bp_count", 32'(resp_count), 1);
      end
      req_valid = 0;
      resp_ready = 1;
      @(negedge clk);
      chk("post_accept_idle", 32'(req_ready), 1);
      chk("post_accept_valid", 32'(resp_valid), 0);
      issue(16'h1212, 16'hFFFF, 1, 1, 8'h12, 9'd1, 19, 1); wait_resp();

      issue(16'h0000, 16'h0000, 0, 0, 8'h00, 9'd0, 0, 0);
      begin
         int n = 0;
         while (eval_x != 8'd40 && n < 100) begin @(negedge clk); n++; end
         chk("reach_cnt40", 32'(eval_x), 40);
      end
      rst = 1;
      @(negedge clk);
      chk("mid_rst_ready", 32'(req_ready), 1);
      chk("mid_rst_eval_x", 32'(eval_x), 0);
      chk("mid_rst_valid", 32'(resp_valid), 0);
      chk("mid_rst_count", 32'(resp_count), 0);
      rst = 0;
      issue(16'h2020, 16'hFFFF, 1, 1, 8'h20, 9'd1, 33, 1); wait_resp();

      repeat (3) @(negedge clk);
      if (q.size() != 0) chk("queue_drained", 32'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/pla_inverse_search.md
# pla_inverse_search

Sequential inverse-lookup engine for the team's combinational PLA blocks, which map an NI-bit input code to an NO-bit output word. Given a target output pattern and a care mask, it sweeps input codes through an external evaluation port driving the PLA under test. It reports either the first matching input code or the total number of matching codes. It sits beside a PLA instance as its reader/inverter, for characterisation, self-test and reverse mapping.

## Interface

Parameters:
- `NI`, default 8: PLA input width; the sweep covers 2^NI codes.
- `NO`, default 16: PLA output width.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: block idle and able to accept a request.
- `req_target`, in, NO: required output pattern.
- `req_mask`, in, NO: care bits; 1 means the bit must match.
- `req_first_only`, in, 1: 1 stops at the first match; 0 counts all matches.
- `eval_x`, out, NI: candidate input code driven to the PLA.
- `eval_z`, in, NO: PLA output for `eval_x`, combinational and valid in the same cycle.
- `resp_valid`, out, 1: result present.
- `resp_ready`, in, 1: consumer accepts the result.
- `resp_found`, out, 1: at least one match.
- `resp_x`, out, NI: lowest matching code; 0 if none.
- `resp_count`, out, NI+1: number of matches, range 0..2^NI. Always 1 when found in first-only mode.

## Operation

- FSM states: IDLE, SCAN, RESP.
- IDLE
  - `req_ready` = 1; it is combinational from the state.
  - On `req_valid & req_ready`: capture target, mask and first_only; clear cnt, count and found; go to SCAN.
- SCAN
  - `eval_x` = cnt.
  - Match condition: `((eval_z ^ target) & mask) == 0`.
  - On a match with found = 0: set found = 1 and resp_x = cnt.
  - On any match: increment count.
  - Terminate to RESP when (first_only & match) or cnt == 2^NI−1. Otherwise cnt += 1.
  - In the terminating cycle, the final match is already folded into count and found.
- RESP
  - `resp_valid` = 1, with found, x and count held stable.
  - On `resp_valid & resp_ready`: go to IDLE and clear `resp_valid`.
- Captured request fields are immune to later input changes.
- `req_ready` = 0 in SCAN and RESP; a `req_valid` in those states is ignored, not queued.
- Width rules:
  - count is NI+1 bits so that 2^NI cannot wrap.
  - cnt is NI bits and is never incremented past 2^NI−1.
- mask = 0: every code matches.
  - Count mode: count = 2^NI, x = 0.
  - First-only mode: x = 0 after one scan cycle.
- `eval_x` = 0 outside SCAN.

## Timing

- Reset values:
  - State IDLE, so `req_ready` = 1 from the first cycle after reset.
  - `resp_valid`, `resp_found`, `resp_x`, `resp_count` and `eval_x` all 0.
- `rst` asserted in any state, including mid-SCAN or mid-RESP, aborts the operation. The next cycle shows the reset values, and any pending result is discarded.
- Latency is counted from the accepting edge: a scan terminating at code k raises `resp_valid` k+1 edges later.
  - Full sweep: 2^NI edges (256 at default).
  - First-only match at k: k+1 edges.
- No back-to-back overlap: after the response-accept edge, the earliest new request accept is the following edge.
- The `resp_*` outputs are registered. Back-pressure through `resp_ready` is unbounded.

## Structure

- Shared package `pla_search_pkg` holds:
  - the state enum (IDLE/SCAN/RESP);
  - the default NI/NO localparams;
  - a function returning the masked-compare result.
- The design is a single module with no sub-module. Counter, compare and FSM each fit in one always block.

## Test plan

The bench models the PLA as `eval_z = {x, x}` unless stated otherwise.

- First-only hit: target 0x5A5A, mask 0xFFFF, first_only = 1 -> `resp_valid` 91 edges after accept; found = 1, x = 0x5A, count = 1.
- Count mode: target 0x0003, mask 0x000F, first_only = 0 -> response after 256 edges; found = 1, x = 0x03, count = 16.
- No match: model `eval_z = {x, ~x}`, target 0x0000, mask 0xFFFF -> found = 0, x = 0, count = 0 after 256 edges.
- mask = 0, count mode -> count = 256 (0x100), x = 0, found = 1. Then first_only = 1 -> response 1 edge after accept.
- Back-pressure: hold `resp_ready` low for 10 cycles while toggling `req_valid` and `req_target` -> response fields stable, `req_ready` = 0, no second scan. After the accept, the next request completes correctly.
- Reset mid-scan at cnt = 40 -> next cycle IDLE, `eval_x` = 0, `resp_valid` = 0, `req_ready` = 1. A subsequent request returns correct results.
